// File: rtl/bcd_to_min_bin.sv
// bcd_to_min_bin: sequential BCD-to-binary minute encoder, the reverse path of
// the minute decoder. It takes one BCD minute byte (01..MAX_BCD) from the RTC
// read sequencer and returns the 6-bit index (value - OFFSET) through an
// iterative reverse double-dabble. Both sides use a valid/ready handshake.
//
// Optional feature: define BCD_TO_MIN_BIN_ERRCNT_EN to build a saturating
// counter of rejected inputs on err_count. When it is not defined, the port
// reads 8'h00 and no counter is built.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an input transfer (in_ready = en)
// CHECK  | range/format check of the captured byte
// CONV   | 7 shift/correct iterations of reverse double-dabble
// FIN    | apply OFFSET, load bin_out
// DONE   | present result; out_valid rises one cycle after entry

module bcd_to_min_bin #(
  parameter logic [7:0] MAX_BCD = 8'h59,
  parameter int         OFFSET  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] bcd_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [5:0] bin_out,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CONV  = 3'd2,
    S_FIN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // {bcd[7:0], bin[6:0]}; the BCD digits drain into the binary field.
  logic [14:0] r_sr;
  logic [2:0]  r_cnt;
  logic [5:0]  r_bin;
  logic        r_err;
  logic        r_out_valid;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_invalid;
  logic [7:0]  w_bcd;
  logic [14:0] w_shr;
  logic [14:0] w_step;
  logic [5:0]  w_fin;

  assign in_ready   = (r_state == S_IDLE) && en && !reset;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  assign bin_out   = r_bin;
  assign err       = r_err;
  assign out_valid = r_out_valid;

  assign w_bcd     = r_sr[14:7];
  assign w_invalid = (w_bcd[7:4] > 4'd9) || (w_bcd[3:0] > 4'd9) ||
                     (w_bcd == 8'h00) || (w_bcd > MAX_BCD);

  // Low 6 bits of (bin - OFFSET); identical to a 7-bit subtract truncated.
  assign w_fin = r_sr[5:0] - 6'(OFFSET);

  assign w_shr = {1'b0, r_sr[14:1]};

  // One reverse double-dabble step: shift right, then pull 3 from any BCD
  // nibble that reached 8 so it stays a valid decimal digit after halving.
  always_comb begin
    w_step = w_shr;
    if (w_shr[14:11] >= 4'd8) w_step[14:11] = w_shr[14:11] - 4'd3;
    if (w_shr[10:7]  >= 4'd8) w_step[10:7]  = w_shr[10:7]  - 4'd3;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_xfer) w_next = S_CHECK;
      S_CHECK: w_next = w_invalid ? S_DONE : S_CONV;
      S_CONV:  if (r_cnt == 3'd6) w_next = S_FIN;
      S_FIN:   w_next = S_DONE;
      S_DONE:  if (w_out_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, iterate, finalise and hold the result until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_xfer) r_sr <= {bcd_in, 7'd0};
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (w_invalid) begin
            r_err <= 1'b1;
            r_bin <= '0;
          end
        end
        S_CONV: begin
          r_sr  <= w_step;
          r_cnt <= r_cnt + 3'd1;
        end
        S_FIN: begin
          r_bin <= w_fin;
          r_err <= 1'b0;
        end
        S_DONE: begin
          if (!r_out_valid)   r_out_valid <= 1'b1;
          else if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_TO_MIN_BIN_ERRCNT_EN
  logic [7:0] r_err_count;

  // Count accepted error results, saturating at 8'hFF.
  always_ff @(posedge clk) begin
    if (reset)
      r_err_count <= '0;
    else if (w_out_xfer && r_err && (r_err_count != 8'hFF))
      r_err_count <= r_err_count + 8'd1;
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_bcd_to_min_bin.sv
// Testbench for bcd_to_min_bin: expected {err, bin_out} pushed to a queue when
// an input is driven, popped and compared when the result is presented.

module tb_bcd_to_min_bin;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] bin_out;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_q[$];

  bcd_to_min_bin dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one input through the handshake; returns latency (edges from the
  // input transfer to out_valid) and the presented {err, bin_out}. If
  // out_ready is high the output transfer is also completed.
  task automatic xfer(input logic [7:0] b, output int lat,
                      output logic [6:0] got, output logic tmo);
    int n;
    tmo = 1'b0;
    bcd_in = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) tmo = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 40) tmo = 1'b1;
    got = {err, bin_out};
    if (out_ready && out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bcd_in = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, err, bin_out, in_ready} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got ov=%b err=%b bin=%h rdy=%b exp all 0",
               out_valid, err, bin_out, in_ready);
    end
    n_checks++;
    if (err_count !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_err_count got=%h exp=00", err_count);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready_after got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_first();
    int lat; logic [6:0] got, exp; logic tmo;
    exp_q.push_back(7'h00);
    xfer(8'h01, lat, got, tmo);
    exp = exp_q.pop_front();
    n_checks++;
    if (tmo || got !== exp) begin
      n_errors++;
      $display("FAIL first_result got=%h exp=%h tmo=%b", got, exp, tmo);
    end
    n_checks++;
    if (lat != 10) begin
      n_errors++;
      $display("FAIL first_latency got=%0d exp=10", lat);
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL first_back_to_idle got rdy=%b ov=%b exp rdy=1 ov=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_sweep();
    int lat; logic [6:0] got, exp; logic tmo; logic [7:0] b;
    for (int v = 1; v <= 59; v++) begin
      b = {4'(v / 10), 4'(v % 10)};
      exp_q.push_back({1'b0, 6'(v - 1)});
      xfer(b, lat, got, tmo);
      exp = exp_q.pop_front();
      n_checks++;
      if (tmo || got !== exp) begin
        n_errors++;
        $display("FAIL sweep_%h got=%h exp=%h tmo=%b", b, got, exp, tmo);
      end
      n_checks++;
      if (lat != 10) begin
        n_errors++;
        $display("FAIL sweep_lat_%h got=%0d exp=10", b, lat);
      end
    end
  endtask

  task automatic test_reject();
    int lat; logic [6:0] got, exp; logic tmo;
    logic [7:0] codes[3];
    logic [7:0] exp_cnt;
    codes[0] = 8'h00; codes[1] = 8'h5A; codes[2] = 8'h60;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(7'h40);
      xfer(codes[i], lat, got, tmo);
      exp = exp_q.pop_front();
      n_checks++;
      if (tmo || got !== exp) begin
        n_errors++;
        $display("FAIL reject_%h got=%h exp=%h tmo=%b", codes[i], got, exp, tmo);
      end
      n_checks++;
      if (lat != 2) begin
        n_errors++;
        $display("FAIL reject_lat_%h got=%0d exp=2", codes[i], lat);
      end
    end
`ifdef BCD_TO_MIN_BIN_ERRCNT_EN
    exp_cnt = 8'd3;
`else
    exp_cnt = 8'd0;
`endif
    n_checks++;
    if (err_count !== exp_cnt) begin
      n_errors++;
      $display("FAIL reject_err_count got=%h exp=%h", err_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [6:0] got, exp; logic tmo; int bad;
    out_ready = 1'b0;
    exp_q.push_back(7'h1D);
    xfer(8'h30, lat, got, tmo);
    exp = exp_q.pop_front();
    n_checks++;
    if (tmo || got !== exp) begin
      n_errors++;
      $display("FAIL bp_result got=%h exp=%h tmo=%b", got, exp, tmo);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || {err, bin_out} !== exp || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL bp_hold got %0d bad cycles (last ov=%b v=%h rdy=%b) exp 0",
               bad, out_valid, {err, bin_out}, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_single_xfer got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_enable();
    int bad; int seen;
    en = 1'b0;
    bcd_in = 8'h25;
    in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL en_low_ready got %0d cycles with in_ready high exp 0", bad);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL en_low_no_capture got %0d out_valid cycles exp 0", seen);
    end
    en = 1'b1;
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [6:0] got, exp; logic tmo; int seen;
    bcd_in = 8'h45;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, err, bin_out, in_ready} !== 9'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs got ov=%b err=%b bin=%h rdy=%b exp all 0",
               out_valid, err, bin_out, in_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_idle got rdy=%b exp 1", in_ready);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL midreset_no_output got %0d out_valid cycles exp 0", seen);
    end
    exp_q.push_back(7'h0B);
    xfer(8'h12, lat, got, tmo);
    exp = exp_q.pop_front();
    n_checks++;
    if (tmo || got !== exp || lat != 10) begin
      n_errors++;
      $display("FAIL midreset_next got=%h exp=%h lat=%0d tmo=%b", got, exp, lat, tmo);
    end
  endtask

`ifdef BCD_TO_MIN_BIN_ERRCNT_EN
  task automatic test_saturation();
    int lat; logic [6:0] got, exp; logic tmo; int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back(7'h40);
      xfer(8'h00, lat, got, tmo);
      exp = exp_q.pop_front();
      if (tmo || got !== exp) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL sat_results got %0d bad results exp 0", bad);
    end
    n_checks++;
    if (err_count !== 8'hFF) begin
      n_errors++;
      $display("FAIL sat_err_count got=%h exp=ff", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first();
    test_sweep();
    test_reject();
    test_backpressure();
    test_enable();
    test_reset_mid();
`ifdef BCD_TO_MIN_BIN_ERRCNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_min_bin.md
Name: bcd_to_min_bin

Overview:
- Sequential BCD-to-binary minute encoder. It is the reverse path of the minute decoder.
- Accepts one BCD minute byte read back from the RTC bus (valid range 01..MAX_BCD) and returns the 6-bit binary index (BCD value minus OFFSET).
- Conversion is iterative (reverse double-dabble) with valid/ready handshakes on both sides.
- Sits between the RTC read sequencer and the time-register file.

Parameters:
- MAX_BCD, 8'h59, highest accepted BCD input (inclusive).
- OFFSET, 1, subtracted from the converted value; BCD 8'h01 maps to binary 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  block enable; when low, no new input is accepted.
- bcd_in  input  8  BCD byte {tens[7:4], ones[3:0]}.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept bcd_in.
- bin_out  output  6  converted binary value (0..58 at defaults).
- err  output  1  qualifies bin_out: the input was rejected.
- out_valid  output  1  bin_out/err valid.
- out_ready  input  1  downstream accepts the result.
- err_count  output  8  count of rejected inputs (see Optional Feature).

Behaviour:
- Synchronous reset:
  - state = IDLE.
  - bin_out = 0, err = 0, out_valid = 0, in_ready = 0, err_count = 0.
  - Internal shift register cleared.
  - Reset mid-conversion aborts the conversion; no out_valid is produced for the aborted input.
- Handshake rules:
  - in_ready = (state == IDLE) && en, registered-equivalent (no combinational path from in_valid).
  - Input transfer occurs on the edge where in_valid && in_ready; bcd_in is captured into the 15-bit register {bcd[7:0], bin[6:0]} with bin = 0.
- IDLE -> CHECK:
  - Entered on an input transfer.
- CHECK (1 cycle): invalid if any of the following holds:
  - tens > 9 or ones > 9;
  - bcd == 8'h00;
  - bcd > MAX_BCD.
  - Invalid -> DONE with err = 1, bin_out = 0.
  - Otherwise -> CONV with iteration counter = 0.
- CONV (exactly 7 cycles):
  - Each cycle, shift the 15-bit register right by 1.
  - Then, per BCD nibble of the shifted result, if the nibble is >= 8, subtract 3.
  - Counter increments each cycle; after iteration 6 -> FIN.
- FIN (1 cycle):
  - bin_out = bin[5:0] - OFFSET, computed in 7 bits and truncated to 6 bits.
  - err = 0.
  - -> DONE.
- DONE:
  - out_valid = 1; bin_out and err held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid deasserts on the next edge and state -> IDLE.
  - A new input can be accepted no earlier than the cycle after the output transfer; no overlap.
- Latency, with input transfer at edge k:
  - valid input: out_valid first high after edge k+10 (CHECK k+1, CONV k+2..k+8, FIN k+9, DONE k+10);
  - invalid input: out_valid first high after edge k+2.
- en:
  - Dropping en during CHECK/CONV/FIN/DONE does not stall; the conversion completes and the result is delivered.
  - en only gates acceptance.
- Simultaneous events:
  - reset has priority over every handshake.
  - out_ready while out_valid = 0 is ignored.
- Output range: at defaults the binary range is 0..58 (6'h00..6'h3A); bin_out never exceeds 6'h3A when err = 0.

Optional Feature:
- Macro: BCD_TO_MIN_BIN_ERRCNT_EN.
- Defined:
  - err_count increments by 1 on each output transfer with err = 1.
  - It saturates at 8'hFF (no wrap).
  - Cleared only by reset.
- Undefined:
  - err_count is tied to 8'h00 and the counter logic is not synthesized.
  - The port stays in the interface so instantiations are identical.

Test Plan:
- Reset then en = 1, bcd_in = 8'h01, in_valid pulse, out_ready = 1 -> out_valid after 10 cycles with bin_out = 6'h00, err = 0; in_ready high again the cycle after the transfer.
- bcd_in = 8'h59 -> bin_out = 6'h3A, err = 0. Sweep all 59 valid codes 8'h01..8'h59 -> bin_out = decimal(bcd) - 1 for every code.
- Rejected inputs:
  - bcd_in = 8'h00 -> err = 1, bin_out = 0, out_valid after 2 cycles;
  - bcd_in = 8'h5A -> err = 1;
  - bcd_in = 8'h60 -> err = 1.
  - With the macro: err_count = 3. Without it: err_count = 0.
- Backpressure and enable:
  - out_ready = 0 for 5 cycles after out_valid on input 8'h30 -> bin_out = 6'h1D held stable, in_ready low throughout;
  - release out_ready -> single transfer, then IDLE.
  - en = 0 with in_valid = 1 -> in_ready = 0, no capture.
- Reset asserted during CONV of 8'h45 -> next cycle: all outputs 0, state IDLE, no out_valid. A subsequent 8'h12 converts to 6'h0B.
- Error-counter saturation (macro defined): 260 invalid inputs -> err_count = 8'hFF.
